// File: rtl/gpu_pkg.sv
// Shared GPU display constants and sizing helpers.
// Default mode is 200x600 active with the porch and sync widths below.
package gpu_pkg;

    localparam int DEF_H_ACTIVE = 200;
    localparam int DEF_H_FP     = 10;
    localparam int DEF_H_SYNC   = 32;
    localparam int DEF_H_BP     = 22;

    localparam int DEF_V_ACTIVE = 600;
    localparam int DEF_V_FP     = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 23;

    function automatic int span_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return span_total(active, fp, sync, bp);
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return span_total(active, fp, sync, bp);
    endfunction

    // Never returns less than 1 so a degenerate span still gets a legal vector width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster direction: wrapping position counter with registered sync decode.
// Exposes the post-edge count and active flag so the top can register aligned outputs.
module timing_axis
    import gpu_pkg::*;
#(
    parameter int   ACTIVE = DEF_H_ACTIVE,
    parameter int   FP     = DEF_H_FP,
    parameter int   SYNC   = DEF_H_SYNC,
    parameter int   BP     = DEF_H_BP,
    parameter logic POL    = 1'b1,
    parameter int   W      = clog2(span_total(ACTIVE, FP, SYNC, BP))
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap,
    output logic         sync,
    output logic         active_next
);

    localparam int         TOTAL      = span_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_FIRST = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_LAST  = W'(ACTIVE + FP + SYNC - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);

    logic in_sync_next;

    always_comb begin
        wrap       = advance && (count == LAST);
        count_next = count;
        if (wrap)
            count_next = '0;
        else if (advance)
            count_next = count + W'(1);
        in_sync_next = (count_next >= SYNC_FIRST) && (count_next <= SYNC_LAST);
        active_next  = (count_next < ACT_END);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            sync  <= ~POL;
        end else if (advance) begin
            count <= count_next;
            sync  <= in_sync_next ? POL : ~POL;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: counters, syncs, active enable, line/frame strobes and
// a replicated framebuffer read address whose base is latched only at frame wrap.
module video_timing_gen
    import gpu_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1,
    parameter int   H_SHIFT   = 1,
    parameter int   V_SHIFT   = 3,
    parameter int   FB_STRIDE = 128,
    parameter int   ADDR_W    = 16,
    localparam int  H_TOTAL   = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
    localparam int  V_TOTAL   = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
    localparam int  H_W       = clog2(H_TOTAL),
    localparam int  V_W       = clog2(V_TOTAL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [ADDR_W-1:0] baseAddr,
    output logic [H_W-1:0]    hCount,
    output logic [V_W-1:0]    vCount,
    output logic              hSync,
    output logic              vSync,
    output logic              oe,
    output logic [ADDR_W-1:0] addr,
    output logic              lineStart,
    output logic              frameStart,
    output logic              vBlank
);

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        (H_ACTIVE >> H_SHIFT) > FB_STRIDE) begin : g_bad_params
        $error("video_timing_gen: illegal porch/sync widths or FB_STRIDE too small");
    end

    localparam logic [V_W-1:0] ROW_MASK = V_W'((1 << V_SHIFT) - 1);

    logic [H_W-1:0]    h_next;
    logic [V_W-1:0]    v_next;
    logic              h_wrap;
    logic              v_wrap;
    logic              h_act_next;
    logic              v_act_next;
    logic              oe_next;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] line_base_next;
    logic [ADDR_W-1:0] addr_next;

    timing_axis #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL), .W(H_W)
    ) u_h_axis (
        .clk        (clk),
        .rst        (rst),
        .advance    (en),
        .count      (hCount),
        .count_next (h_next),
        .wrap       (h_wrap),
        .sync       (hSync),
        .active_next(h_act_next)
    );

    timing_axis #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL), .W(V_W)
    ) u_v_axis (
        .clk        (clk),
        .rst        (rst),
        .advance    (h_wrap),
        .count      (vCount),
        .count_next (v_next),
        .wrap       (v_wrap),
        .sync       (vSync),
        .active_next(v_act_next)
    );

    // line_base tracks frameBase + (vCount >> V_SHIFT) * FB_STRIDE; at frame wrap it
    // reloads from baseAddr, which doubles as the once-per-frame base capture.
    always_comb begin
        line_base_next = line_base;
        if (v_wrap)
            line_base_next = baseAddr;
        else if (h_wrap && ((v_next & ROW_MASK) == '0))
            line_base_next = line_base + ADDR_W'(FB_STRIDE);
        oe_next   = h_act_next && v_act_next;
        addr_next = oe_next ? line_base_next + ADDR_W'(h_next >> H_SHIFT) : addr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_base  <= '0;
            addr       <= '0;
            oe         <= 1'b1;
            vBlank     <= 1'b0;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else begin
            lineStart  <= h_wrap;
            frameStart <= v_wrap;
            if (en) begin
                line_base <= line_base_next;
                addr      <= addr_next;
                oe        <= oe_next;
                vBlank    <= !v_act_next;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: two small-mode instances (replicated / unreplicated,
// opposite sync polarity) checked against an arithmetic raster model plus directed tables.
module tb_video_timing_gen;

    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3, HT = 24;
    localparam int VA = 16, VFP = 1, VSY = 2, VBP = 2, VT = 21;
    localparam int HSH[2] = '{1, 0};
    localparam int VSH[2] = '{2, 0};
    localparam int STR[2] = '{8, 16};
    localparam bit POL[2] = '{1'b1, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [15:0] base = '0;

    logic [4:0]  hc [2];
    logic [4:0]  vc [2];
    logic        hs [2];
    logic        vs [2];
    logic        oe [2];
    logic        vb [2];
    logic        ls [2];
    logic        fs [2];
    logic [15:0] ad [2];

    int tests = 0;
    int fails = 0;

    int mh [2], mv [2], mbase [2], maddr [2];
    bit mls [2], mfs [2];

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .H_SHIFT(1), .V_SHIFT(2),
        .FB_STRIDE(8), .ADDR_W(16)
    ) dut0 (
        .clk(clk), .rst(rst), .en(en), .baseAddr(base),
        .hCount(hc[0]), .vCount(vc[0]), .hSync(hs[0]), .vSync(vs[0]), .oe(oe[0]),
        .addr(ad[0]), .lineStart(ls[0]), .frameStart(fs[0]), .vBlank(vb[0])
    );

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .H_SHIFT(0), .V_SHIFT(0),
        .FB_STRIDE(16), .ADDR_W(16)
    ) dut1 (
        .clk(clk), .rst(rst), .en(en), .baseAddr(base),
        .hCount(hc[1]), .vCount(vc[1]), .hSync(hs[1]), .vSync(vs[1]), .oe(oe[1]),
        .addr(ad[1]), .lineStart(ls[1]), .frameStart(fs[1]), .vBlank(vb[1])
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mh[i] = 0; mv[i] = 0; mbase[i] = 0; maddr[i] = 0;
            mls[i] = 1'b0; mfs[i] = 1'b0;
        end
    endtask

    // Raster position advances; address recomputed from scratch with a multiply.
    task automatic model_step(input logic e, input logic [15:0] b);
        for (int i = 0; i < 2; i++) begin
            if (e) begin
                if (mh[i] == HT - 1) begin
                    mh[i] = 0;
                    if (mv[i] == VT - 1) begin
                        mv[i] = 0;
                        mbase[i] = int'(b);
                    end else begin
                        mv[i] = mv[i] + 1;
                    end
                end else begin
                    mh[i] = mh[i] + 1;
                end
                mls[i] = (mh[i] == 0);
                mfs[i] = (mh[i] == 0) && (mv[i] == 0);
                if (mh[i] < HA && mv[i] < VA)
                    maddr[i] = (mbase[i] + (mv[i] >> VSH[i]) * STR[i] + (mh[i] >> HSH[i])) % 65536;
            end else begin
                mls[i] = 1'b0;
                mfs[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        int  eh, ev, ea;
        bit  ehs, evs, eoe, evb;
        for (int i = 0; i < 2; i++) begin
            eh  = mh[i];
            ev  = mv[i];
            ea  = maddr[i];
            ehs = (mh[i] >= HA + HFP && mh[i] < HA + HFP + HSY) ? POL[i] : !POL[i];
            evs = (mv[i] >= VA + VFP && mv[i] < VA + VFP + VSY) ? POL[i] : !POL[i];
            eoe = (mh[i] < HA) && (mv[i] < VA);
            evb = (mv[i] >= VA);
            tests++;
            if (int'(hc[i]) != eh || int'(vc[i]) != ev || hs[i] !== ehs || vs[i] !== evs ||
                oe[i] !== eoe || vb[i] !== evb || ls[i] !== mls[i] || fs[i] !== mfs[i] ||
                int'(ad[i]) != ea) begin
                fails++;
                $display("FAIL dut%0d_model got h=%0d v=%0d hs=%b vs=%b oe=%b vb=%b ls=%b fs=%b addr=%h, required h=%0d v=%0d hs=%b vs=%b oe=%b vb=%b ls=%b fs=%b addr=%h",
                         i, hc[i], vc[i], hs[i], vs[i], oe[i], vb[i], ls[i], fs[i], ad[i],
                         eh, ev, ehs, evs, eoe, evb, mls[i], mfs[i], ea[15:0]);
            end
        end
    endtask

    task automatic tick(input logic e, input logic [15:0] b);
        en   = e;
        base = b;
        @(posedge clk);
        model_step(e, b);
        #1;
        check_all();
    endtask

    task automatic check_count(input string name, input int got, input int req);
        tests++;
        if (got != req) begin
            fails++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    typedef struct {
        int          adv;
        logic [15:0] b;
        int          h;
        int          v;
        logic        eoe;
        logic [15:0] eaddr;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int n_ls, n_fs, n_hs, n_vs;
        logic [15:0] rb;

        // Directed walk for dut0 (H_SHIFT=1, V_SHIFT=2, stride 8), starting from reset.
        tbl[0]  = '{1,   16'h1000, 1,  0,  1'b1, 16'h0000};
        tbl[1]  = '{1,   16'h1000, 2,  0,  1'b1, 16'h0001};
        tbl[2]  = '{3,   16'h1000, 5,  0,  1'b1, 16'h0002};
        tbl[3]  = '{11,  16'h1000, 16, 0,  1'b0, 16'h0007};
        tbl[4]  = '{8,   16'h1000, 0,  1,  1'b1, 16'h0000};
        tbl[5]  = '{63,  16'h1000, 15, 3,  1'b1, 16'h0007};
        tbl[6]  = '{9,   16'h1000, 0,  4,  1'b1, 16'h0008};
        tbl[7]  = '{279, 16'h1000, 15, 15, 1'b1, 16'h001F};
        tbl[8]  = '{1,   16'h1000, 16, 15, 1'b0, 16'h001F};
        tbl[9]  = '{8,   16'h1000, 0,  16, 1'b0, 16'h001F};
        tbl[10] = '{119, 16'h1000, 23, 20, 1'b0, 16'h001F};
        tbl[11] = '{1,   16'h1000, 0,  0,  1'b1, 16'h1000};
        tbl[12] = '{375, 16'h1000, 15, 15, 1'b1, 16'h101F};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b1;
        tick(1'b0, 16'h0000);
        tick(1'b0, 16'h0000);

        // One full frame of continuous enable.
        n_ls = 0; n_fs = 0; n_hs = 0; n_vs = 0;
        for (int k = 0; k < HT * VT; k++) begin
            tick(1'b1, 16'h0ABC);
            n_ls += int'(ls[0]);
            n_fs += int'(fs[0]);
            n_hs += int'(hs[0]);
            n_vs += int'(vs[0]);
        end
        check_count("frame_linestarts", n_ls, VT);
        check_count("frame_framestarts", n_fs, 1);
        check_count("frame_hsync_cycles", n_hs, VT * HSY);
        check_count("frame_vsync_cycles", n_vs, VSY * HT);

        // Mid-frame asynchronous reset at (10,12), observed before the next edge.
        for (int k = 0; k < 12 * HT + 10; k++) tick(1'b1, 16'h0ABC);
        check_count("pre_reset_h", int'(hc[0]), 10);
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
        #1;

        for (int r = 0; r < 13; r++) begin
            for (int k = 0; k < tbl[r].adv; k++) tick(1'b1, tbl[r].b);
            tests++;
            if (int'(hc[0]) != tbl[r].h || int'(vc[0]) != tbl[r].v ||
                oe[0] !== tbl[r].eoe || ad[0] !== tbl[r].eaddr) begin
                fails++;
                $display("FAIL table_row%0d got h=%0d v=%0d oe=%b addr=%h, required h=%0d v=%0d oe=%b addr=%h",
                         r, hc[0], vc[0], oe[0], ad[0], tbl[r].h, tbl[r].v, tbl[r].eoe, tbl[r].eaddr);
            end
        end

        // Enable one cycle in three for a full frame's worth of pixels.
        for (int k = 0; k < 3 * HT * VT; k++) tick((k % 3) == 0, 16'h2345);

        // Random enable and occasional base changes, including wrapping bases.
        rb = 16'hFFF0;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 149) == 0) rb = 16'($urandom);
            tick($urandom_range(0, 3) != 0, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
